// File: rtl/ddr3_loopback_traffic_checker.sv
// Write/read-back traffic source for the ddr3_memory_controller user port.
// Ports: clk/reset, start, controller status in, requests/data out, pass/fail stats.
module ddr3_loopback_traffic_checker #(
  parameter int DQ_BITWIDTH = 16,
  parameter int USER_ADDR_BITWIDTH = 17,
  parameter int STATE_BITWIDTH = 5,
  parameter int STATE_WRITE_DATA = 8,
  parameter int STATE_READ_DATA = 11,
  parameter int NUM_OF_TEST_DATA = 8,
  parameter logic [DQ_BITWIDTH-1:0] PATTERN_SEED = 16'hA5C3,
  parameter logic [DQ_BITWIDTH-1:0] PATTERN_STEP = 16'h0101,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [STATE_BITWIDTH-1:0]     main_state,
  input  logic                          beat_strobe,
  input  logic [DQ_BITWIDTH-1:0]        data_from_ram,
  input  logic                          data_from_ram_valid,
  output logic                          write_enable,
  output logic                          read_enable,
  output logic [USER_ADDR_BITWIDTH-1:0] i_user_data_address,
  output logic [DQ_BITWIDTH-1:0]        data_to_ram,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic                          timeout,
  output logic [15:0]                   error_count,
  output logic [USER_ADDR_BITWIDTH-1:0] first_error_index
);

  localparam int AW = USER_ADDR_BITWIDTH;
  localparam int CW = USER_ADDR_BITWIDTH + 1;
  localparam logic [CW-1:0] NUM_C = CW'(NUM_OF_TEST_DATA);
  localparam logic [31:0] TO_C = 32'(TIMEOUT_CYCLES);
  localparam logic [STATE_BITWIDTH-1:0] SW_C = STATE_BITWIDTH'(STATE_WRITE_DATA);
  localparam logic [STATE_BITWIDTH-1:0] SR_C = STATE_BITWIDTH'(STATE_READ_DATA);

  typedef enum logic [1:0] {
    S_IDLE, S_WRITE, S_READ, S_DONE
  } state_e;

  state_e state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, ferr_q, ferr_d;
  logic [DQ_BITWIDTH-1:0] data_q, data_d, exp_q, exp_d;
  logic we_q, we_d, re_q, re_d, busy_q, busy_d;
  logic done_q, done_d, pass_q, pass_d, to_q, to_d;
  logic seen_q, seen_d;
  logic [15:0] err_q, err_d;
  logic [CW-1:0] wr_q, wr_d, rd_q, rd_d, rx_q, rx_d;
  logic [31:0] prog_q, prog_d;
  logic wr_acc, rd_acc, rx_acc, active;

  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    data_d = data_q;
    exp_d = exp_q;
    we_d = we_q;
    re_d = re_q;
    busy_d = busy_q;
    done_d = done_q;
    pass_d = pass_q;
    to_d = to_q;
    err_d = err_q;
    ferr_d = ferr_q;
    seen_d = seen_q;
    wr_d = wr_q;
    rd_d = rd_q;
    rx_d = rx_q;
    prog_d = prog_q;

    active = (state_q == S_WRITE) || (state_q == S_READ);
    wr_acc = (state_q == S_WRITE) && (main_state == SW_C) && beat_strobe;
    rd_acc = (state_q == S_READ) && (main_state == SR_C)
             && beat_strobe && re_q;
    // Valids outside READ or beyond the last word are stray and dropped.
    rx_acc = (state_q == S_READ) && data_from_ram_valid && (rx_q != NUM_C);

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WRITE;
          addr_d = '0;
          data_d = PATTERN_SEED;
          exp_d = PATTERN_SEED;
          we_d = 1'b1;
          re_d = 1'b0;
          busy_d = 1'b1;
          done_d = 1'b0;
          pass_d = 1'b0;
          to_d = 1'b0;
          err_d = '0;
          ferr_d = '0;
          seen_d = 1'b0;
          wr_d = '0;
          rd_d = '0;
          rx_d = '0;
          prog_d = '0;
        end
      end
      S_WRITE: begin
        if (wr_acc) begin
          addr_d = addr_q + 1'b1;
          data_d = data_q + PATTERN_STEP;
          wr_d = wr_q + 1'b1;
          if (wr_q + 1'b1 == NUM_C) begin
            we_d = 1'b0;
            re_d = 1'b1;
            addr_d = '0;
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (rd_acc) begin
          addr_d = addr_q + 1'b1;
          rd_d = rd_q + 1'b1;
          if (rd_q + 1'b1 == NUM_C) re_d = 1'b0;
        end
        if (rx_acc) begin
          exp_d = exp_q + PATTERN_STEP;
          rx_d = rx_q + 1'b1;
          if (data_from_ram != exp_q) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (!seen_q) begin
              seen_d = 1'b1;
              ferr_d = rx_q[AW-1:0];
            end
          end
          if (rx_q + 1'b1 == NUM_C) begin
            state_d = S_DONE;
            re_d = 1'b0;
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = (err_d == '0);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Watchdog: any accepted beat, request or valid counts as progress.
    if (active) begin
      if (wr_acc || rd_acc || rx_acc) begin
        prog_d = '0;
      end else if (prog_q + 32'd1 == TO_C) begin
        state_d = S_DONE;
        to_d = 1'b1;
        we_d = 1'b0;
        re_d = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b1;
        pass_d = 1'b0;
      end else begin
        prog_d = prog_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      data_q <= '0;
      exp_q <= '0;
      we_q <= 1'b0;
      re_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      to_q <= 1'b0;
      err_q <= '0;
      ferr_q <= '0;
      seen_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      rx_q <= '0;
      prog_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      data_q <= data_d;
      exp_q <= exp_d;
      we_q <= we_d;
      re_q <= re_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      to_q <= to_d;
      err_q <= err_d;
      ferr_q <= ferr_d;
      seen_q <= seen_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      rx_q <= rx_d;
      prog_q <= prog_d;
    end
  end

  assign write_enable = we_q;
  assign read_enable = re_q;
  assign i_user_data_address = addr_q;
  assign data_to_ram = data_q;
  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;
  assign timeout = to_q;
  assign error_count = err_q;
  assign first_error_index = ferr_q;

endmodule
